// File: rtl/exc_cp0.sv
// ---------------------------------------------------------------------------
// exc_cp0 -- MIPS-style coprocessor 0 with exception prioritisation.
//
// Purpose:
//   Decides, combinationally, whether the memory-stage instruction raises an
//   exception (or executes ERET), drives the pipeline flush and redirect
//   target in the same cycle, and commits the CP0 register side effects at
//   the next rising clock edge. It also provides the MTC0/MFC0 access port.
//
// Optional feature:
//   CP0_TIMER_INT_EN  - when defined, Count free-runs at half the clock rate
//                       and Count==Compare (Compare!=0) raises Cause.TI,
//                       which is ORed into Cause.IP[7] (bit 15). When not
//                       defined, Count changes only through MTC0 and TI
//                       reads as 0.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   pcM                PC of the memory-stage instruction
//   in_delayslotM      instruction sits in a branch delay slot
//   adelM, adesM       data load / store address error
//   bad_addrM          faulting data address (pcM when no data error)
//   excflagsM          {eret, overflow, reserved_inst, break, syscall}
//   int_i              level-sensitive hardware interrupt lines
//   we_i/waddr_i/wdata_i  MTC0 write port
//   raddr_i/rdata_o    MFC0 read port (combinational, pre-edge values)
//   flush_o, newpc_o   pipeline flush and redirect target
//   excepttype_o       ExcCode in [6:2], 32'h0000000E for ERET, 0 for none
//   epc_o, status_o, cause_o  current register values
//
// Handshake: there is no valid/ready handshake here; every input is
// qualified by the cycle it is presented in, and a committed exception or
// ERET always takes effect at the very next rising edge.
// ---------------------------------------------------------------------------
module exc_cp0 #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pcM,
    input  logic        in_delayslotM,
    input  logic        adelM,
    input  logic        adesM,
    input  logic [31:0] bad_addrM,
    input  logic [4:0]  excflagsM,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] epc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o
);

    // Register addresses
    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // Source selector for the BadVAddr update
    typedef enum logic [1:0] {
        BADV_KEEP = 2'd0,
        BADV_PC   = 2'd1,
        BADV_DATA = 2'd2
    } badv_sel_t;

    // Only the writable / hardware-updated fields are stored; everything
    // else in Status/Cause is a constant and is stitched in on read.
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [1:0]  cause_ipsw;
    logic [4:0]  cause_exc;
    logic        cause_ti;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;

    logic [31:0] status_view;
    logic [31:0] cause_view;
    logic [7:0]  ip_view;

    // Detection results
    logic        int_pending;
    logic        fetch_adel;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        eret_take;
    badv_sel_t   badv_sel;
    logic        mtc0_en;

    logic        f_eret;
    logic        f_ov;
    logic        f_ri;
    logic        f_bp;
    logic        f_sys;

    assign f_eret = excflagsM[4];
    assign f_ov   = excflagsM[3];
    assign f_ri   = excflagsM[2];
    assign f_bp   = excflagsM[1];
    assign f_sys  = excflagsM[0];

    // IP[7:2] follow the interrupt lines directly so an interrupt raised in
    // the same cycle as another event is seen by the prioritiser.
    assign ip_view = {int_i[5] | cause_ti, int_i[4:0], cause_ipsw};

    // Status.BEV (bit 22) is hardwired to 1.
    assign status_view = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_view  = {cause_bd, cause_ti, 14'b0, ip_view, 1'b0, cause_exc, 2'b0};

    assign status_o = status_view;
    assign cause_o  = cause_view;
    assign epc_o    = epc_q;

    // -----------------------------------------------------------------------
    // Exception prioritisation (combinational)
    // -----------------------------------------------------------------------
    assign int_pending = status_ie & ~status_exl & (|(ip_view & status_im));
    assign fetch_adel  = (pcM[1:0] != 2'b00);

    always_comb begin
        exc_valid = 1'b1;
        exc_code  = EXC_INT;
        eret_take = 1'b0;
        badv_sel  = BADV_KEEP;
        if (int_pending) begin
            exc_code = EXC_INT;
        end else if (fetch_adel) begin
            exc_code = EXC_ADEL;
            badv_sel = BADV_PC;
        end else if (f_ri) begin
            exc_code = EXC_RI;
        end else if (f_sys) begin
            exc_code = EXC_SYS;
        end else if (f_bp) begin
            exc_code = EXC_BP;
        end else if (f_ov) begin
            exc_code = EXC_OV;
        end else if (adelM) begin
            exc_code = EXC_ADEL;
            badv_sel = BADV_DATA;
        end else if (adesM) begin
            exc_code = EXC_ADES;
            badv_sel = BADV_DATA;
        end else begin
            exc_valid = 1'b0;
            eret_take = f_eret;
        end
    end

    always_comb begin
        flush_o      = exc_valid | eret_take;
        newpc_o      = 32'h0;
        excepttype_o = 32'h0;
        if (exc_valid) begin
            newpc_o      = EXC_VECTOR;
            excepttype_o = {25'b0, exc_code, 2'b0};
        end else if (eret_take) begin
            newpc_o      = epc_q;
            excepttype_o = 32'h0000000E;
        end
    end

    // An exception or ERET in the same cycle wins over a software write.
    assign mtc0_en = we_i & ~exc_valid & ~eret_take;

    // -----------------------------------------------------------------------
    // MFC0 read port: always the registered (pre-edge) values
    // -----------------------------------------------------------------------
    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            ADDR_BADVADDR: rdata_o = badvaddr_q;
            ADDR_COUNT:    rdata_o = count_q;
            ADDR_COMPARE:  rdata_o = compare_q;
            ADDR_STATUS:   rdata_o = status_view;
            ADDR_CAUSE:    rdata_o = cause_view;
            ADDR_EPC:      rdata_o = epc_q;
            default:       rdata_o = 32'h0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Status / Cause / EPC / BadVAddr / Compare
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im  <= 8'h0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
            cause_bd   <= 1'b0;
            cause_ipsw <= 2'b0;
            cause_exc  <= 5'h0;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
            compare_q  <= 32'h0;
        end else if (exc_valid) begin
            status_exl <= 1'b1;
            cause_bd   <= in_delayslotM;
            cause_exc  <= exc_code;
            // A delay-slot fault restarts at the branch that owns the slot.
            epc_q      <= in_delayslotM ? (pcM - 32'd4) : pcM;
            case (badv_sel)
                BADV_PC:   badvaddr_q <= pcM;
                BADV_DATA: badvaddr_q <= bad_addrM;
                default:   badvaddr_q <= badvaddr_q;
            endcase
        end else if (eret_take) begin
            status_exl <= 1'b0;
        end else if (mtc0_en) begin
            case (waddr_i)
                ADDR_STATUS: begin
                    status_im  <= wdata_i[15:8];
                    status_exl <= wdata_i[1];
                    status_ie  <= wdata_i[0];
                end
                ADDR_CAUSE:   cause_ipsw <= wdata_i[9:8];
                ADDR_EPC:     epc_q      <= wdata_i;
                ADDR_COMPARE: compare_q  <= wdata_i;
                default: ;
            endcase
        end
    end

`ifdef CP0_TIMER_INT_EN
    // -----------------------------------------------------------------------
    // Free-running timer: Count advances on every second clock edge.
    // -----------------------------------------------------------------------
    logic tick_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_q  <= 1'b0;
            count_q <= 32'h0;
        end else begin
            tick_q <= ~tick_q;
            if (mtc0_en && (waddr_i == ADDR_COUNT)) begin
                count_q <= wdata_i;
            end else if (tick_q) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // TI is sticky until software rewrites Compare; a zero Compare never
    // matches so an unprogrammed timer stays silent.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cause_ti <= 1'b0;
        end else if (mtc0_en && (waddr_i == ADDR_COMPARE)) begin
            cause_ti <= 1'b0;
        end else if ((compare_q != 32'h0) && (count_q == compare_q)) begin
            cause_ti <= 1'b1;
        end
    end
`else
    // Count is a plain software register; no timer interrupt.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= 32'h0;
        end else if (mtc0_en && (waddr_i == ADDR_COUNT)) begin
            count_q <= wdata_i;
        end
    end

    assign cause_ti = 1'b0;
`endif

endmodule

// File: tb/tb_exc_cp0.sv
// ---------------------------------------------------------------------------
// tb_exc_cp0 -- directed, table-driven bench for exc_cp0 (default build,
// timer feature disabled).
// ---------------------------------------------------------------------------
module tb_exc_cp0;

    logic        clk;
    logic        resetn;
    logic [31:0] pcM;
    logic        in_delayslotM;
    logic        adelM;
    logic        adesM;
    logic [31:0] bad_addrM;
    logic [4:0]  excflagsM;
    logic [5:0]  int_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic        flush_o;
    logic [31:0] newpc_o;
    logic [31:0] excepttype_o;
    logic [31:0] epc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;

    int checks;
    int errors;

    localparam logic [31:0] VEC = 32'hBFC00380;

    exc_cp0 #(.EXC_VECTOR(VEC)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pcM           (pcM),
        .in_delayslotM (in_delayslotM),
        .adelM         (adelM),
        .adesM         (adesM),
        .bad_addrM     (bad_addrM),
        .excflagsM     (excflagsM),
        .int_i         (int_i),
        .we_i          (we_i),
        .waddr_i       (waddr_i),
        .wdata_i       (wdata_i),
        .raddr_i       (raddr_i),
        .rdata_o       (rdata_o),
        .flush_o       (flush_o),
        .newpc_o       (newpc_o),
        .excepttype_o  (excepttype_o),
        .epc_o         (epc_o),
        .status_o      (status_o),
        .cause_o       (cause_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        pcM           = 32'h80000000;
        in_delayslotM = 1'b0;
        adelM         = 1'b0;
        adesM         = 1'b0;
        bad_addrM     = 32'h80000000;
        excflagsM     = 5'b0;
        we_i          = 1'b0;
        waddr_i       = 5'd0;
        wdata_i       = 32'h0;
    endtask

    // Step to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        idle_inputs();
        we_i    = 1'b1;
        waddr_i = addr;
        wdata_i = data;
        step();
        we_i = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] pc;
        logic        ds;
        logic        adel;
        logic        ades;
        logic [31:0] bad;
        logic [4:0]  flags;   // {eret, ov, ri, bp, sys}
        logic        flush;
        logic [31:0] etype;
        logic [31:0] npc;
        logic [31:0] epc;     // expected after the edge
        logic [31:0] badv;
        logic [31:0] status;
        logic [31:0] cause;
    } vec_t;

    vec_t vecs[13];

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        int_i   = 6'b0;
        raddr_i = 5'd8;
        resetn  = 1'b0;

        // Entries are applied back to back; post-edge columns accumulate.
        vecs[0]  = '{32'hBFC00100, 1'b0, 1'b1, 1'b0, 32'h00000003, 5'b00000, 1'b1, 32'h10, VEC,
                     32'hBFC00100, 32'h00000003, 32'h00400002, 32'h00000010};
        vecs[1]  = '{32'hBFC00202, 1'b0, 1'b0, 1'b0, 32'hBFC00202, 5'b00001, 1'b1, 32'h10, VEC,
                     32'hBFC00202, 32'hBFC00202, 32'h00400002, 32'h00000010};
        vecs[2]  = '{32'h80000010, 1'b1, 1'b0, 1'b1, 32'h80000040, 5'b00000, 1'b1, 32'h14, VEC,
                     32'h8000000C, 32'h80000040, 32'h00400002, 32'h80000014};
        vecs[3]  = '{32'h80000100, 1'b0, 1'b0, 1'b0, 32'h80000100, 5'b00101, 1'b1, 32'h28, VEC,
                     32'h80000100, 32'h80000040, 32'h00400002, 32'h00000028};
        vecs[4]  = '{32'h80000200, 1'b0, 1'b0, 1'b0, 32'h80000200, 5'b00011, 1'b1, 32'h20, VEC,
                     32'h80000200, 32'h80000040, 32'h00400002, 32'h00000020};
        vecs[5]  = '{32'h80000300, 1'b0, 1'b0, 1'b0, 32'h80000300, 5'b01010, 1'b1, 32'h24, VEC,
                     32'h80000300, 32'h80000040, 32'h00400002, 32'h00000024};
        vecs[6]  = '{32'h80000400, 1'b0, 1'b1, 1'b0, 32'h00001234, 5'b01000, 1'b1, 32'h30, VEC,
                     32'h80000400, 32'h80000040, 32'h00400002, 32'h00000030};
        vecs[7]  = '{32'h80000500, 1'b0, 1'b1, 1'b1, 32'h00001235, 5'b00000, 1'b1, 32'h10, VEC,
                     32'h80000500, 32'h00001235, 32'h00400002, 32'h00000010};
        vecs[8]  = '{32'h80000600, 1'b0, 1'b0, 1'b0, 32'h80000600, 5'b10000, 1'b1, 32'h0E, 32'h80000500,
                     32'h80000500, 32'h00001235, 32'h00400000, 32'h00000010};
        vecs[9]  = '{32'h80000700, 1'b0, 1'b0, 1'b0, 32'h80000700, 5'b00000, 1'b0, 32'h00, 32'h0,
                     32'h80000500, 32'h00001235, 32'h00400000, 32'h00000010};
        vecs[10] = '{32'h80000800, 1'b1, 1'b0, 1'b0, 32'h80000800, 5'b11000, 1'b1, 32'h30, VEC,
                     32'h800007FC, 32'h00001235, 32'h00400002, 32'h80000030};
        vecs[11] = '{32'h80000803, 1'b0, 1'b0, 1'b0, 32'h80000803, 5'b10000, 1'b1, 32'h10, VEC,
                     32'h80000803, 32'h80000803, 32'h00400002, 32'h00000010};
        vecs[12] = '{32'h80000900, 1'b0, 1'b0, 1'b0, 32'h80000900, 5'b10000, 1'b1, 32'h0E, 32'h80000803,
                     32'h80000803, 32'h80000803, 32'h00400000, 32'h00000010};

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_status", status_o, 32'h00400000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_badv", rdata_o, 32'h0);
        chk("rst_flush", {31'b0, flush_o}, 32'h0);
        resetn = 1'b1;
        step();

        // ---------------- table ----------------
        for (int i = 0; i < 13; i++) begin
            pcM           = vecs[i].pc;
            in_delayslotM = vecs[i].ds;
            adelM         = vecs[i].adel;
            adesM         = vecs[i].ades;
            bad_addrM     = vecs[i].bad;
            excflagsM     = vecs[i].flags;
            @(negedge clk);
            chk($sformatf("v%0d_flush", i), {31'b0, flush_o}, {31'b0, vecs[i].flush});
            chk($sformatf("v%0d_etype", i), excepttype_o, vecs[i].etype);
            chk($sformatf("v%0d_newpc", i), newpc_o, vecs[i].npc);
            step();
            idle_inputs();
            chk($sformatf("v%0d_epc", i), epc_o, vecs[i].epc);
            chk($sformatf("v%0d_badv", i), rdata_o, vecs[i].badv);
            chk($sformatf("v%0d_status", i), status_o, vecs[i].status);
            chk($sformatf("v%0d_cause", i), cause_o, vecs[i].cause);
        end

        // ---------------- MTC0 writable masks ----------------
        mtc0(5'd12, 32'hFFFFFFFF);
        chk("wr_status_mask", status_o, 32'h0040FF03);
        mtc0(5'd13, 32'hFFFFFFFF);
        chk("wr_cause_mask", cause_o, 32'h00000310);

        // ---------------- interrupt beats overflow, then ERET ----------------
        mtc0(5'd12, 32'h00000401);
        chk("wr_status_int", status_o, 32'h00400401);
        idle_inputs();
        pcM       = 32'h80001000;
        bad_addrM = 32'h80001000;
        excflagsM = 5'b01000;
        int_i     = 6'b000001;
        @(negedge clk);
        chk("int_flush", {31'b0, flush_o}, 32'h1);
        chk("int_etype", excepttype_o, 32'h0);
        chk("int_newpc", newpc_o, VEC);
        step();
        idle_inputs();
        chk("int_status", status_o, 32'h00400403);
        chk("int_epc", epc_o, 32'h80001000);
        chk("int_cause", cause_o, 32'h00000700);
        // EXL masks the still-asserted line.
        @(negedge clk);
        chk("int_masked", {31'b0, flush_o}, 32'h0);
        step();
        excflagsM = 5'b10000;
        @(negedge clk);
        chk("eret_flush", {31'b0, flush_o}, 32'h1);
        chk("eret_etype", excepttype_o, 32'h0000000E);
        chk("eret_newpc", newpc_o, 32'h80001000);
        step();
        idle_inputs();
        int_i = 6'b0;
        chk("eret_status", status_o, 32'h00400401);

        // ---------------- MTC0 suppressed by simultaneous exception ----------------
        idle_inputs();
        pcM       = 32'h80002000;
        adesM     = 1'b1;
        bad_addrM = 32'h00000044;
        we_i      = 1'b1;
        waddr_i   = 5'd12;
        wdata_i   = 32'h0000FF00;
        @(negedge clk);
        chk("sup_etype", excepttype_o, 32'h14);
        step();
        idle_inputs();
        chk("sup_status", status_o, 32'h00400403);
        chk("sup_badv", rdata_o, 32'h00000044);

        // ---------------- read port: pre-edge values, other regs ----------------
        raddr_i = 5'd14;
        we_i    = 1'b1;
        waddr_i = 5'd14;
        wdata_i = 32'h12345678;
        @(negedge clk);
        chk("rd_preedge", rdata_o, 32'h80002000);
        step();
        idle_inputs();
        chk("rd_postedge", rdata_o, 32'h12345678);
        mtc0(5'd9, 32'h00000007);
        repeat (3) step();
        raddr_i = 5'd9;
        #1;
        chk("count_static", rdata_o, 32'h00000007);
        mtc0(5'd11, 32'h00000055);
        raddr_i = 5'd11;
        #1;
        chk("compare_rd", rdata_o, 32'h00000055);
        mtc0(5'd8, 32'h0000DEAD);
        raddr_i = 5'd8;
        #1;
        chk("badv_readonly", rdata_o, 32'h00000044);
        raddr_i = 5'd5;
        #1;
        chk("rd_unmapped", rdata_o, 32'h0);

        // ---------------- asynchronous reset mid-cycle ----------------
        idle_inputs();
        pcM   = 32'h80003000;
        adelM = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_status", status_o, 32'h00400000);
        chk("arst_epc", epc_o, 32'h0);
        chk("arst_cause", cause_o, 32'h0);
        step();
        resetn = 1'b1;
        idle_inputs();
        chk("arst_no_commit", epc_o, 32'h0);
        mtc0(5'd14, 32'hA5A5A5A4);
        chk("post_rst_write", epc_o, 32'hA5A5A5A4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if anything above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
